ssp_dmem_port_arbiter: RTL

- Shares the processor's single data-memory port between the two issue lanes of the 2-way superscalar pipeline.
- Lane 0 is the older instruction in program order; lane 1 is the younger.
- Captures a lane pair's LW/SW requests, serialises them in program order, and applies two shortcuts: SW→LW store-to-load forwarding and same-address LW merging.
- Holds the pipeline stalled until the whole pair completes. A per-access watchdog flags a memory port that never acknowledges.

---
 rtl/ssp_pkg.sv | 28 ++
 rtl/ssp_mem_watchdog.sv | 39 +++
 rtl/ssp_dmem_port_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ssp_pkg.sv
// ---------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the superscalar pipeline's memory-side blocks:
// instruction opcode constants, default data-memory geometry and the state
// encoding of the data-memory port arbiter FSM.
// ---------------------------------------------------------------------------
package ssp_pkg;

  // Default data-memory geometry (11-bit word address, 32-bit words)
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  // Memory-class opcodes as decoded by the issue stage
  localparam logic [5:0] OP_LW  = 6'b010000;
  localparam logic [5:0] OP_SW  = 6'b010001;
  localparam logic [5:0] OP_NOP = 6'b111111;

  // Data-memory port arbiter states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_DONE   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/ssp_mem_watchdog.sv
// ---------------------------------------------------------------------------
// ssp_mem_watchdog
// Per-access timeout counter for a memory port. The count restarts on i_clr
// and advances on every cycle i_en is high. o_expire is raised during the
// enabled cycle in which the count has reached TIMEOUT-1, i.e. on the
// TIMEOUT-th consecutive enabled cycle since the last clear.
//
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_clr     restart the count (start of a new access)
//   i_en      count this cycle (waiting, no acknowledge)
//   o_expire  timeout reached in this cycle
// ---------------------------------------------------------------------------
module ssp_mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ssp_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// ssp_dmem_port_arbiter
// Shares the single data-memory port between the two issue lanes of the
// 2-way superscalar pipeline. A lane pair's LW/SW requests are captured,
// issued in program order (lane 0 first) and the pipeline is stalled until
// the pair is complete. A lane-1 LW to the same word as lane 0 is satisfied
// without a second access: from lane 0's store data (SW->LW forwarding) or
// from lane 0's read data (LW merge). A watchdog bounds every wait for
// mem_ack; on expiry err is set (sticky), the load result is zero and the
// sequence continues as if acknowledged.
//
// Ports:
//   clk1, reset              clock, synchronous active-high reset
//   mreq0/1 mwe0/1           lane request, 1=SW 0=LW
//   maddr0/1 mwdata0/1       lane word address, store data
//   stall                    hold both lanes (requests stay stable)
//   pair_done                one-cycle pulse when the pair is complete
//   rdata0/1                 load results, valid from pair_done
//   mem_en mem_we            access strobe and write enable
//   mem_addr mem_wdata       access address and write data
//   mem_ack mem_rdata        access complete, read data
//   err                      sticky access timeout flag
// ---------------------------------------------------------------------------
module ssp_dmem_port_arbiter
  import ssp_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              mreq0,
  input  logic              mreq1,
  input  logic              mwe0,
  input  logic              mwe1,
  input  logic [ADDR_W-1:0] maddr0,
  input  logic [ADDR_W-1:0] maddr1,
  input  logic [DATA_W-1:0] mwdata0,
  input  logic [DATA_W-1:0] mwdata1,
  output logic              stall,
  output logic              pair_done,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_t        r_state;
  logic              r_req1;
  logic              r_we0, r_we1;
  logic [ADDR_W-1:0] r_addr0, r_addr1;
  logic [DATA_W-1:0] r_wdata0, r_wdata1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic              r_mem_en, r_mem_we, r_pair_done, r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_wait, w_busy, w_expire, w_acc, w_merge1;
  logic [DATA_W-1:0] w_ld_data;

  assign w_wait = (r_state == ST_WAIT0) || (r_state == ST_WAIT1);
  assign w_busy = w_wait || (r_state == ST_ISSUE0) || (r_state == ST_ISSUE1);

  ssp_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk    (clk1),
    .i_rst    (reset),
    .i_clr    ((r_state == ST_ISSUE0) || (r_state == ST_ISSUE1)),
    .i_en     (w_wait && !mem_ack),
    .o_expire (w_expire)
  );

  // An access ends on acknowledge or on watchdog expiry; an expired load
  // returns zero instead of whatever is on the bus.
  assign w_acc     = w_wait && (mem_ack || w_expire);
  assign w_ld_data = w_expire ? '0 : mem_rdata;

  // Lane 1 is a load of the word lane 0 just touched: no second access.
  // Covers SW->LW forwarding and LW/LW merging; SW/SW is never merged.
  assign w_merge1 = r_req1 && !r_we1 && (r_addr1 == r_addr0);

  // Capture cycle stalls combinationally; held low during reset so all
  // outputs read zero while reset is asserted.
  assign stall = w_busy || ((r_state == ST_IDLE) && (mreq0 || mreq1) && !reset);

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req1      <= 1'b0;
      r_we0       <= 1'b0;
      r_we1       <= 1'b0;
      r_addr0     <= '0;
      r_addr1     <= '0;
      r_wdata0    <= '0;
      r_wdata1    <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pair_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Strobes and access fields are registered and only live for the
      // single ISSUEx cycle they are set up for.
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pair_done <= 1'b0;
      if (w_expire) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (mreq0 || mreq1) begin
            r_req1   <= mreq1;
            r_we0    <= mwe0;
            r_we1    <= mwe1;
            r_addr0  <= maddr0;
            r_addr1  <= maddr1;
            r_wdata0 <= mwdata0;
            r_wdata1 <= mwdata1;
            r_mem_en <= 1'b1;
            if (mreq0) begin
              r_state     <= ST_ISSUE0;
              r_mem_we    <= mwe0;
              r_mem_addr  <= maddr0;
              r_mem_wdata <= mwdata0;
            end else begin
              r_state     <= ST_ISSUE1;
              r_mem_we    <= mwe1;
              r_mem_addr  <= maddr1;
              r_mem_wdata <= mwdata1;
            end
          end
        end
        ST_ISSUE0: r_state <= ST_WAIT0;
        ST_WAIT0: begin
          if (w_acc) begin
            if (!r_we0) r_rdata0 <= w_ld_data;
            if (w_merge1) begin
              r_rdata1    <= r_we0 ? r_wdata0 : w_ld_data;
              r_state     <= ST_DONE;
              r_pair_done <= 1'b1;
            end else if (r_req1) begin
              r_state     <= ST_ISSUE1;
              r_mem_en    <= 1'b1;
              r_mem_we    <= r_we1;
              r_mem_addr  <= r_addr1;
              r_mem_wdata <= r_wdata1;
            end else begin
              r_state     <= ST_DONE;
              r_pair_done <= 1'b1;
            end
          end
        end
        ST_ISSUE1: r_state <= ST_WAIT1;
        ST_WAIT1: begin
          if (w_acc) begin
            if (!r_we1) r_rdata1 <= w_ld_data;
            r_state     <= ST_DONE;
            r_pair_done <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pair_done = r_pair_done;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;

endmodule
